data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LINE_W, default 256: width of one memory line in bits.
REQ-002 Parameter DEPTH, default 512: number of lines (16 KB total).
REQ-003 Parameter LATENCY, default 10: cycles from request acceptance to ack_o.
REQ-004 clk_i  input  1: single clock, all state updates on rising edge.
REQ-005 rst_i  input  1: reset, synchronous and active-high.
REQ-006 addr_i  input  32: byte address; line index = addr_i[13:5] (log2(DEPTH)+4 : 5), other bits ignored.
REQ-007 data_i  input  LINE_W: write data, one full line.
REQ-008 enable_i  input  1: request valid.
REQ-009 write_i  input  1: 1 = write, 0 = read; qualified by enable_i.
REQ-010 ack_o  output  1: one-cycle completion pulse.
REQ-011 data_o  output  LINE_W: read data, valid while ack_o = 1.

Function
REQ-012 Storage SHALL be a reg array named "memory", DEPTH entries of LINE_W bits, hierarchically writable by benches for preload/flush.
REQ-013 FSM states SHALL be IDLE, WAIT, ACK.
REQ-014 In IDLE, enable_i = 1 at edge N SHALL latch addr_i index, data_i and write_i, clear the latency counter, and move to WAIT.
REQ-015 In WAIT the counter SHALL increment each edge; at edge N+LATENCY the FSM SHALL enter ACK.
REQ-016 At edge N+LATENCY a latched write SHALL commit the latched data to memory[index]; a latched read SHALL register memory[index] into data_o.
REQ-017 ack_o SHALL be 1 exactly during the cycle after edge N+LATENCY (state ACK), 0 otherwise.
REQ-018 ACK SHALL return to IDLE unconditionally at edge N+LATENCY+1; the earliest next acceptance is edge N+LATENCY+2.
REQ-019 Changes on enable_i, addr_i, data_i, write_i while in WAIT or ACK SHALL be ignored; the request is not aborted.
REQ-020 Read-after-write to the same line SHALL return the newly written data.
REQ-021 On a write, data_o SHALL hold its previous value.
REQ-022 Addresses above 16 KB SHALL alias by truncation to the index bits; no error signal.
REQ-023 Counter SHALL be wide enough for LATENCY (at least clog2(LATENCY+1) bits); no wrap-around occurs within a transaction.

Reset
REQ-024 rst_i = 1 at an edge SHALL force state IDLE, counter 0, ack_o 0, data_o 0, with priority over all other activity, including mid-transaction (pending write discarded).
REQ-025 Reset SHALL NOT clear the memory array; preloaded contents survive reset.

Structure
REQ-026 A shared package SHALL hold LINE_W, DEPTH, LATENCY defaults, the address-field constants (offset bits 5, index width 9) and the FSM state typedef.
REQ-027 The block SHALL be a single module with no sub-modules; FSM, counter and array are inline.

Verification
REQ-028 Preload memory[0] = 0x5, read addr 0x0 at edge N -> ack_o high only in cycle N+10, data_o = 0x...05.
REQ-029 Write 0xA5A5 to addr 0x400 (index 32), then read 0x400 -> second ack returns 0xA5A5; memory[32] = 0xA5A5 after the first ack edge.
REQ-030 enable_i held high continuously with reads -> ack pulses spaced exactly LATENCY+2 cycles apart, never two consecutive ack cycles.
REQ-031 Change addr_i and data_i during WAIT of a write to 0x20 -> only memory[1] is updated, with the originally latched data.
REQ-032 Assert rst_i at WAIT cycle 5 of a write to 0x40 -> no ack, memory[2] unchanged, data_o = 0, next request completes normally.
REQ-033 Read addr 0x4020 (beyond 16 KB) -> returns memory[1] contents.

Source files
------------

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared defaults, address-field constants and FSM state type for data_memory
package data_memory_pkg;
  localparam int DEF_LINE_W  = 256;
  localparam int DEF_DEPTH   = 512;
  localparam int DEF_LATENCY = 10;
  localparam int OFFSET_BITS = 5;
  localparam int INDEX_W     = 9;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;
endpackage

// File: rtl/data_memory.sv
// data_memory: fixed-latency line memory (clk_i, rst_i, addr_i, data_i, enable_i, write_i -> ack_o, data_o)
module data_memory
  import data_memory_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  logic [LINE_W-1:0] memory [DEPTH];
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, data_q, data_d;
  logic write_q, write_d, ack_q, ack_d;
  logic accept, done;
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:OFFSET_BITS+IDX_W], addr_i[OFFSET_BITS-1:0]};
  assign accept = state_q == IDLE && enable_i;
  assign done   = state_q == WAIT && cnt_q == CNT_W'(LATENCY - 1);
  always_comb begin
    state_d = accept ? WAIT : done ? ACK : state_q == ACK ? IDLE : state_q;
    cnt_d   = accept ? '0 : state_q == WAIT ? cnt_q + 1'b1 : cnt_q;
    idx_d   = accept ? addr_i[OFFSET_BITS +: IDX_W] : idx_q;
    wdata_d = accept ? data_i : wdata_q;
    write_d = accept ? write_i : write_q;
    ack_d   = done;
    data_d  = done && !write_q ? memory[idx_q] : data_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end
  // the array is never reset; a reset on the commit edge drops the pending write
  always_ff @(posedge clk_i) begin
    if (!rst_i && done && write_q) memory[idx_q] <= wdata_q;
  end
  assign ack_o  = ack_q;
  assign data_o = data_q;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized self-checking bench for data_memory against a line-array model
module tb_data_memory;
  localparam int LW  = 256;
  localparam int DEP = 512;
  localparam int LAT = 10;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [31:0] addr_i = '0;
  logic [LW-1:0] data_i = '0;
  logic enable_i = 1'b0;
  logic write_i = 1'b0;
  logic ack_o;
  logic [LW-1:0] data_o;
  logic [LW-1:0] mem_m [DEP];
  logic [LW-1:0] rd_m;
  int checks = 0;
  int errors = 0;
  data_memory dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
    .enable_i(enable_i), .write_i(write_i), .ack_o(ack_o), .data_o(data_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % DEP);
  endfunction
  task automatic txn(input logic [31:0] a, input logic [LW-1:0] d, input logic w, input bit jit, input string name);
    int lat;
    lat = -1;
    addr_i = a; data_i = d; write_i = w; enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (jit) begin
        addr_i = $urandom; data_i = rand_line(); write_i = 1'($urandom % 2); enable_i = 1'($urandom % 2);
      end
      @(posedge clk_i); #1;
      if (ack_o) begin
        lat = i;
        break;
      end
    end
    enable_i = 1'b0;
    if (w) mem_m[line_of(a)] = d;
    else rd_m = mem_m[line_of(a)];
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT); end
    checks++;
    if (data_o !== rd_m) begin errors++; $display("FAIL %s data_o: got %h expected %h", name, data_o, rd_m); end
    @(posedge clk_i); #1;
    checks++;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL %s ack_width: got %b expected 0", name, ack_o); end
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rd_m = '0;
    checks++;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL reset ack_o: got %b expected 0", ack_o); end
    checks++;
    if (data_o !== '0) begin errors++; $display("FAIL reset data_o: got %h expected 0", data_o); end
  endtask
  task automatic test_preload_read();
    dut.memory[0] = LW'(5);
    mem_m[0] = LW'(5);
    txn(32'h0, '0, 1'b0, 1'b0, "preload_read");
  endtask
  task automatic test_write_read();
    txn(32'h400, LW'(16'hA5A5), 1'b1, 1'b0, "write_400");
    checks++;
    if (dut.memory[32] !== LW'(16'hA5A5)) begin errors++; $display("FAIL write_commit mem32: got %h expected %h", dut.memory[32], LW'(16'hA5A5)); end
    txn(32'h400, '0, 1'b0, 1'b0, "read_400");
  endtask
  task automatic test_back_to_back();
    int acks, prev, gap_err;
    bit last;
    logic [31:0] a;
    a = 32'h0000_0060;
    acks = 0; prev = -1; gap_err = 0; last = 1'b0;
    addr_i = a; write_i = 1'b0; enable_i = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin
        if (last) gap_err++;
        if (prev < 0 ? i != LAT + 1 : i - prev != LAT + 2) gap_err++;
        if (data_o !== mem_m[line_of(a)]) gap_err++;
        prev = i;
        acks++;
      end
      last = ack_o;
    end
    enable_i = 1'b0;
    rd_m = mem_m[line_of(a)];
    checks++;
    if (acks != 5) begin errors++; $display("FAIL back_to_back count: got %0d expected 5", acks); end
    checks++;
    if (gap_err != 0) begin errors++; $display("FAIL back_to_back spacing/data: got %0d bad acks expected 0", gap_err); end
    repeat (LAT + 2) @(posedge clk_i);
    #1;
  endtask
  task automatic test_ignore_changes();
    logic [LW-1:0] d;
    int bad;
    d = rand_line();
    txn(32'h20, d, 1'b1, 1'b1, "ignore_changes");
    checks++;
    if (dut.memory[1] !== d) begin errors++; $display("FAIL ignore_changes mem1: got %h expected %h", dut.memory[1], d); end
    bad = 0;
    for (int k = 0; k < DEP; k++) if (dut.memory[k] !== mem_m[k]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ignore_changes array: got %0d differing lines expected 0", bad); end
  endtask
  task automatic test_reset_mid();
    int seen;
    seen = 0;
    addr_i = 32'h40; data_i = rand_line(); write_i = 1'b1; enable_i = 1'b1;
    @(posedge clk_i); #1;
    enable_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    rd_m = '0;
    checks++;
    if (data_o !== '0) begin errors++; $display("FAIL reset_mid data_o: got %h expected 0", data_o); end
    for (int i = 0; i < 15; i++) begin
      if (ack_o) seen++;
      @(posedge clk_i); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid ack: got %0d acks expected 0", seen); end
    checks++;
    if (dut.memory[2] !== mem_m[2]) begin errors++; $display("FAIL reset_mid mem2: got %h expected %h", dut.memory[2], mem_m[2]); end
    txn(32'h40, '0, 1'b0, 1'b0, "after_reset_read");
  endtask
  task automatic test_alias();
    txn(32'h4020, '0, 1'b0, 1'b0, "alias_4020");
  endtask
  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      if ($urandom % 2) a = {a[31:14], 9'($urandom % 4), a[4:0]};
      txn(a, rand_line(), 1'($urandom % 2), 1'($urandom % 2), "random");
    end
  endtask
  initial begin
    for (int k = 0; k < DEP; k++) begin
      mem_m[k] = rand_line();
      dut.memory[k] = mem_m[k];
    end
    test_reset();
    test_preload_read();
    test_write_read();
    test_back_to_back();
    test_ignore_changes();
    test_reset_mid();
    test_alias();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
